// File: rtl/mem_stage.sv
// mem_stage: load/store pipeline stage with valid/ready handshakes and one outstanding data-memory access.
// Optional misaligned-access trap is enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage (
   input  logic        i_clk,
   input  logic        i_rst_n,
   // upstream
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_load,
   input  logic        i_store,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_rs2_data,
   input  logic [4:0]  i_rd,
   input  logic        i_reg_write,
   // data memory
   output logic        o_dmem_req,
   output logic        o_dmem_wen,
   output logic [31:0] o_dmem_addr,
   output logic [3:0]  o_dmem_mask,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_gnt,
   input  logic        i_dmem_rvalid,
   input  logic [31:0] i_dmem_rdata,
   // downstream
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_wb_data,
   output logic [4:0]  o_rd,
   output logic        o_reg_write,
   output logic        o_trap
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RDW  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   state_t            r_state, w_state_nxt;
   logic              r_store, w_store_nxt;
   logic [2:0]        r_funct3, w_funct3_nxt;
   logic [1:0]        r_off, w_off_nxt;

   logic              w_req_nxt, w_wen_nxt, w_valid_nxt, w_rw_nxt, w_trap_nxt;
   logic [XLEN-1:0]   w_addr_nxt, w_wdata_nxt, w_wb_nxt;
   logic [3:0]        w_mask_nxt;
   logic [RDW-1:0]    w_rd_nxt;

   logic              w_can_accept, w_take, w_mem_op, w_mis;
   logic [1:0]        w_size;
   logic [3:0]        w_st_mask;
   logic [XLEN-1:0]   w_st_wdata;

   // Access size; undefined codes fall back to a full word.
   function automatic logic [1:0] acc_size(input logic store, input logic [2:0] f3);
      logic [1:0] sz;
      sz = SZ_W;
      if (store) begin
         if (f3 == 3'b000)      sz = SZ_B;
         else if (f3 == 3'b001) sz = SZ_H;
      end else begin
         if (f3[1:0] == 2'b00)      sz = SZ_B;
         else if (f3[1:0] == 2'b01) sz = SZ_H;
      end
      return sz;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b100:  res = {24'd0, b};
         3'b101:  res = {16'd0, h};
         default: res = rdata;
      endcase
      return res;
   endfunction

   assign w_can_accept = (r_state == IDLE) || ((r_state == HOLD) && i_ready);
   assign w_take       = i_valid && w_can_accept;
   assign o_ready      = i_rst_n && w_can_accept;
   assign w_mem_op     = i_load || i_store;
   assign w_size       = acc_size(i_store, i_funct3);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign w_mis = w_mem_op &&
                  (((w_size == SZ_H) && i_alu_result[0]) ||
                   ((w_size == SZ_W) && (i_alu_result[1:0] != 2'b00)));
`else
   assign w_mis = 1'b0;
`endif

   // Store byte lanes and replicated write data.
   always_comb begin
      w_st_mask  = 4'b1111;
      w_st_wdata = i_rs2_data;
      case (w_size)
         SZ_B: begin
            w_st_mask  = 4'(4'b0001 << i_alu_result[1:0]);
            w_st_wdata = {4{i_rs2_data[7:0]}};
         end
         SZ_H: begin
            w_st_mask  = i_alu_result[1] ? 4'b1100 : 4'b0011;
            w_st_wdata = {2{i_rs2_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Next state and next values of every registered output.
   always_comb begin
      w_state_nxt  = r_state;
      w_store_nxt  = r_store;
      w_funct3_nxt = r_funct3;
      w_off_nxt    = r_off;
      w_req_nxt    = o_dmem_req;
      w_wen_nxt    = o_dmem_wen;
      w_addr_nxt   = o_dmem_addr;
      w_mask_nxt   = o_dmem_mask;
      w_wdata_nxt  = o_dmem_wdata;
      w_valid_nxt  = o_valid;
      w_wb_nxt     = o_wb_data;
      w_rd_nxt     = o_rd;
      w_rw_nxt     = o_reg_write;
      w_trap_nxt   = o_trap;

      case (r_state)
         REQ: begin
            if (i_dmem_gnt) begin
               w_req_nxt = 1'b0;
               if (r_store) begin
                  w_state_nxt = HOLD;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (i_dmem_rvalid) begin
               w_wb_nxt    = load_extract(i_dmem_rdata, r_funct3, r_off);
               w_valid_nxt = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (i_ready) begin
               w_valid_nxt = 1'b0;
               w_trap_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: ;
      endcase

      // A new transaction overrides IDLE and a completing HOLD.
      if (w_take) begin
         w_store_nxt  = i_store;
         w_funct3_nxt = i_funct3;
         w_off_nxt    = i_alu_result[1:0];
         w_wen_nxt    = i_store;
         w_rd_nxt     = i_rd;
         w_trap_nxt   = 1'b0;
         if (w_mis) begin
            w_state_nxt = HOLD;
            w_valid_nxt = 1'b1;
            w_trap_nxt  = 1'b1;
            w_rw_nxt    = 1'b0;
            w_wb_nxt    = i_alu_result;
         end else if (w_mem_op) begin
            w_state_nxt = REQ;
            w_valid_nxt = 1'b0;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = {i_alu_result[31:2], 2'b00};
            w_mask_nxt  = i_store ? w_st_mask : 4'b1111;
            w_wdata_nxt = w_st_wdata;
            w_rw_nxt    = i_store ? 1'b0 : i_reg_write;
         end else begin
            w_state_nxt = HOLD;
            w_valid_nxt = 1'b1;
            w_wb_nxt    = i_alu_result;
            w_rw_nxt    = i_reg_write;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_store      <= 1'b0;
         r_funct3     <= 3'd0;
         r_off        <= 2'd0;
         o_dmem_req   <= 1'b0;
         o_dmem_wen   <= 1'b0;
         o_dmem_addr  <= '0;
         o_dmem_mask  <= 4'd0;
         o_dmem_wdata <= '0;
         o_valid      <= 1'b0;
         o_wb_data    <= '0;
         o_rd         <= '0;
         o_reg_write  <= 1'b0;
         o_trap       <= 1'b0;
      end else begin
         r_store      <= w_store_nxt;
         r_funct3     <= w_funct3_nxt;
         r_off        <= w_off_nxt;
         o_dmem_req   <= w_req_nxt;
         o_dmem_wen   <= w_wen_nxt;
         o_dmem_addr  <= w_addr_nxt;
         o_dmem_mask  <= w_mask_nxt;
         o_dmem_wdata <= w_wdata_nxt;
         o_valid      <= w_valid_nxt;
         o_wb_data    <= w_wb_nxt;
         o_rd         <= w_rd_nxt;
         o_reg_write  <= w_rw_nxt;
         o_trap       <= w_trap_nxt;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expected values are hand-computed.
`timescale 1ns/1ps
module tb_mem_stage;

   logic        i_clk, i_rst_n;
   logic        i_valid, o_ready, i_load, i_store;
   logic [2:0]  i_funct3;
   logic [31:0] i_alu_result, i_rs2_data;
   logic [4:0]  i_rd;
   logic        i_reg_write;
   logic        o_dmem_req, o_dmem_wen;
   logic [31:0] o_dmem_addr, o_dmem_wdata;
   logic [3:0]  o_dmem_mask;
   logic        i_dmem_gnt, i_dmem_rvalid;
   logic [31:0] i_dmem_rdata;
   logic        o_valid, i_ready;
   logic [31:0] o_wb_data;
   logic [4:0]  o_rd;
   logic        o_reg_write, o_trap;

   int n_chk  = 0;
   int n_pass = 0;

   mem_stage dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_valid(i_valid), .o_ready(o_ready), .i_load(i_load), .i_store(i_store),
      .i_funct3(i_funct3), .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data),
      .i_rd(i_rd), .i_reg_write(i_reg_write),
      .o_dmem_req(o_dmem_req), .o_dmem_wen(o_dmem_wen), .o_dmem_addr(o_dmem_addr),
      .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
      .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
      .o_valid(o_valid), .i_ready(i_ready), .o_wb_data(o_wb_data), .o_rd(o_rd),
      .o_reg_write(o_reg_write), .o_trap(o_trap)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // One-cycle upstream transfer; returns 1ns after the accepting edge.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rw);
      i_load = ld; i_store = st; i_funct3 = f3; i_alu_result = addr;
      i_rs2_data = rs2; i_rd = rd; i_reg_write = rw; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   // Load issued from IDLE with immediate grant and data; returns in HOLD.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
      issue(1'b1, 1'b0, f3, addr, 32'd0, 5'd6, 1'b1);
      i_dmem_gnt = 1'b1;
      tick();
      i_dmem_gnt = 1'b0;
      i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
      tick();
      i_dmem_rvalid = 1'b0;
   endtask

   initial begin
      i_rst_n = 1'b1; i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_funct3 = 3'd0;
      i_alu_result = 32'd0; i_rs2_data = 32'd0; i_rd = 5'd0; i_reg_write = 1'b0;
      i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0; i_ready = 1'b1;

      // Reset values
      #1 i_rst_n = 1'b0;
      #2;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_req",   32'(o_dmem_req), 32'd0);
      chk("rst_wb",    o_wb_data, 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      tick(); tick();
      i_rst_n = 1'b1;
      #1;
      chk("idle_ready", 32'(o_ready), 32'd1);

      // Pass-through, one-cycle latency
      issue(1'b0, 1'b0, 3'b000, 32'h12345678, 32'd0, 5'd5, 1'b1);
      chk("pt_valid", 32'(o_valid), 32'd1);
      chk("pt_wb",    o_wb_data, 32'h12345678);
      chk("pt_rd",    32'(o_rd), 32'd5);
      chk("pt_rw",    32'(o_reg_write), 32'd1);
      chk("pt_ready", 32'(o_ready), 32'd1);
      chk("pt_req",   32'(o_dmem_req), 32'd0);
      tick();
      chk("pt_done_valid", 32'(o_valid), 32'd0);

      // LB at 0x1003, step by step
      issue(1'b1, 1'b0, 3'b000, 32'h00001003, 32'd0, 5'd6, 1'b1);
      chk("lb_req",   32'(o_dmem_req), 32'd1);
      chk("lb_addr",  o_dmem_addr, 32'h00001000);
      chk("lb_mask",  32'(o_dmem_mask), 32'hF);
      chk("lb_wen",   32'(o_dmem_wen), 32'd0);
      chk("lb_ready", 32'(o_ready), 32'd0);
      i_dmem_gnt = 1'b1;
      tick();
      i_dmem_gnt = 1'b0;
      chk("lb_wait_req",   32'(o_dmem_req), 32'd0);
      chk("lb_wait_valid", 32'(o_valid), 32'd0);
      i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h80000000;
      tick();
      i_dmem_rvalid = 1'b0;
      chk("lb_valid", 32'(o_valid), 32'd1);
      chk("lb_wb",    o_wb_data, 32'hFFFFFF80);
      chk("lb_rw",    32'(o_reg_write), 32'd1);
      tick();

      // LBU, LH, LHU
      do_load(3'b100, 32'h00001003, 32'h80000000);
      chk("lbu_wb", o_wb_data, 32'h00000080);
      tick();
      do_load(3'b001, 32'h00004002, 32'h80011234);
      chk("lh_wb", o_wb_data, 32'hFFFF8001);
      tick();
      do_load(3'b101, 32'h00004000, 32'h80019234);
      chk("lhu_wb", o_wb_data, 32'h00009234);
      tick();

      // SH at 0x2002, grant after 3 cycles, downstream stalls 2 cycles
      i_ready = 1'b0;
      issue(1'b0, 1'b1, 3'b001, 32'h00002002, 32'h0000BEEF, 5'd7, 1'b1);
      chk("sh_req",   32'(o_dmem_req), 32'd1);
      chk("sh_addr",  o_dmem_addr, 32'h00002000);
      chk("sh_mask",  32'(o_dmem_mask), 32'hC);
      chk("sh_wdata", o_dmem_wdata, 32'hBEEFBEEF);
      chk("sh_wen",   32'(o_dmem_wen), 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("sh_stall_req",   32'(o_dmem_req), 32'd1);
         chk("sh_stall_addr",  o_dmem_addr, 32'h00002000);
         chk("sh_stall_mask",  32'(o_dmem_mask), 32'hC);
         chk("sh_stall_ready", 32'(o_ready), 32'd0);
      end
      i_dmem_gnt = 1'b1;
      tick();
      i_dmem_gnt = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("sh_hold_valid", 32'(o_valid), 32'd1);
         chk("sh_hold_rw",    32'(o_reg_write), 32'd0);
         chk("sh_hold_rd",    32'(o_rd), 32'd7);
         chk("sh_hold_req",   32'(o_dmem_req), 32'd0);
         chk("sh_hold_ready", 32'(o_ready), 32'd0);
         tick();
      end
      chk("sh_still_valid", 32'(o_valid), 32'd1);
      i_ready = 1'b1;
      #1;
      chk("sh_release_ready", 32'(o_ready), 32'd1);
      tick();
      chk("sh_done_valid", 32'(o_valid), 32'd0);

      // SB at 0x5001
      issue(1'b0, 1'b1, 3'b000, 32'h00005001, 32'h123456A5, 5'd3, 1'b1);
      chk("sb_mask",  32'(o_dmem_mask), 32'h2);
      chk("sb_wdata", o_dmem_wdata, 32'hA5A5A5A5);
      chk("sb_addr",  o_dmem_addr, 32'h00005000);
      i_dmem_gnt = 1'b1;
      tick();
      i_dmem_gnt = 1'b0;
      chk("sb_valid", 32'(o_valid), 32'd1);
      tick();

      // LW at misaligned 0x3001
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      issue(1'b1, 1'b0, 3'b010, 32'h00003001, 32'd0, 5'd8, 1'b1);
      chk("lw_mis_req",   32'(o_dmem_req), 32'd0);
      chk("lw_mis_valid", 32'(o_valid), 32'd1);
      chk("lw_mis_trap",  32'(o_trap), 32'd1);
      chk("lw_mis_wb",    o_wb_data, 32'h00003001);
      chk("lw_mis_rw",    32'(o_reg_write), 32'd0);
      tick();
      chk("lw_mis_trap_clr", 32'(o_trap), 32'd0);
`else
      issue(1'b1, 1'b0, 3'b010, 32'h00003001, 32'd0, 5'd8, 1'b1);
      chk("lw_mis_req",  32'(o_dmem_req), 32'd1);
      chk("lw_mis_addr", o_dmem_addr, 32'h00003000);
      chk("lw_mis_mask", 32'(o_dmem_mask), 32'hF);
      i_dmem_gnt = 1'b1;
      tick();
      i_dmem_gnt = 1'b0;
      i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFEF00D;
      tick();
      i_dmem_rvalid = 1'b0;
      chk("lw_mis_wb",   o_wb_data, 32'hCAFEF00D);
      chk("lw_mis_trap", 32'(o_trap), 32'd0);
      tick();
`endif

      // Back-to-back accept from HOLD
      issue(1'b0, 1'b0, 3'b000, 32'h00000011, 32'd0, 5'd9, 1'b1);
      chk("b2b_first_wb", o_wb_data, 32'h00000011);
      i_valid = 1'b1; i_alu_result = 32'h00000022; i_rd = 5'd10;
      #1;
      chk("b2b_ready", 32'(o_ready), 32'd1);
      tick();
      i_valid = 1'b0;
      chk("b2b_valid", 32'(o_valid), 32'd1);
      chk("b2b_wb",    o_wb_data, 32'h00000022);
      chk("b2b_rd",    32'(o_rd), 32'd10);
      tick();
      chk("b2b_done_valid", 32'(o_valid), 32'd0);

      // Reset while waiting for read data, then a stray rvalid/gnt
      issue(1'b1, 1'b0, 3'b010, 32'h00006000, 32'd0, 5'd11, 1'b1);
      i_dmem_gnt = 1'b1;
      tick();
      i_dmem_gnt = 1'b0;
      chk("wr_wait_req", 32'(o_dmem_req), 32'd0);
      i_rst_n = 1'b0;
      #1;
      chk("wr_rst_valid", 32'(o_valid), 32'd0);
      chk("wr_rst_addr",  o_dmem_addr, 32'd0);
      chk("wr_rst_mask",  32'(o_dmem_mask), 32'd0);
      chk("wr_rst_rd",    32'(o_rd), 32'd0);
      chk("wr_rst_wb",    o_wb_data, 32'd0);
      chk("wr_rst_ready", 32'(o_ready), 32'd0);
      tick();
      i_rst_n = 1'b1;
      i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h55555555; i_dmem_gnt = 1'b1;
      tick();
      chk("wr_stray_valid", 32'(o_valid), 32'd0);
      tick();
      i_dmem_rvalid = 1'b0; i_dmem_gnt = 1'b0;
      chk("wr_stray_valid2", 32'(o_valid), 32'd0);
      chk("wr_stray_wb",     o_wb_data, 32'd0);
      chk("wr_stray_req",    32'(o_dmem_req), 32'd0);
      chk("wr_idle_ready",   32'(o_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
